// File: rtl/wb_wport_arbiter_pkg.sv
// Shared definitions for the writeback write-port arbiter: the EX->WB bus layout and the
// arbiter FSM encoding.
package wb_wport_arbiter_pkg;

  localparam int unsigned ES_TO_WS_BUS_WD = 70;
  localparam int unsigned WE_BIT          = 69;
  localparam int unsigned DEST_MSB        = 68;
  localparam int unsigned DEST_LSB        = 64;
  localparam int unsigned RES_MSB         = 63;
  localparam int unsigned RES_LSB         = 32;
  localparam int unsigned DEST_W          = DEST_MSB - DEST_LSB + 1;
  localparam int unsigned RES_W           = RES_MSB - RES_LSB + 1;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [DEST_W-1:0] dest;
    logic [RES_W-1:0]  result;
    logic [31:0]       pc;
  } wb_bus_t;

endpackage

// File: rtl/wb_wport_arbiter_llu.sv
// Two-entry FIFO holding long-latency-unit results until a write port is free.
// A push is refused whenever the FIFO is full, even if it pops in the same cycle.
module wb_llu_fifo
  import wb_wport_arbiter_pkg::*;
#(
  parameter int unsigned W = ES_TO_WS_BUS_WD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_wport_arbiter.sv
// Writeback stage: schedules two regfile write ports between the dual ALU lanes and the
// buffered LLU results, with WAW suppression and a forced LLU slot against starvation.
module wb_wport_arbiter
  import wb_wport_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BUS_WD     = ES_TO_WS_BUS_WD
) (
  input  logic              clk,
  input  logic              reset,
  output logic              lanes_ready,
  input  logic              l1_valid,
  input  logic [BUS_WD-1:0] l1_bus,
  input  logic              l2_valid,
  input  logic [BUS_WD-1:0] l2_bus,
  input  logic              llu_valid,
  output logic              llu_ready,
  input  logic [BUS_WD-1:0] llu_bus,
  output logic              wp1_we,
  output logic [4:0]        wp1_addr,
  output logic [31:0]       wp1_data,
  output logic              wp2_we,
  output logic [4:0]        wp2_addr,
  output logic [31:0]       wp2_data,
  output logic [31:0]       llu_force_cnt
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              force_slot;
  logic [SW-1:0]     starve_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [BUS_WD-1:0] head_raw;
  wb_bus_t           b1;
  wb_bus_t           b2;
  wb_bus_t           head;
  wb_bus_t           p1;
  wb_bus_t           p2;
  logic              p1_vld;
  logic              p2_vld;
  logic              p1_llu;
  logic              p2_llu;
  logic              l1_wr;
  logic              l2_wr;
  logic              p1_we;
  logic              p2_we;
  logic              unused_pc;

  assign b1        = wb_bus_t'(l1_bus);
  assign b2        = wb_bus_t'(l2_bus);
  assign head      = wb_bus_t'(head_raw);
  assign llu_ready = !fifo_full;
  assign unused_pc = ^{b1.pc, b2.pc, head.pc};

  wb_llu_fifo #(.W(BUS_WD)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (llu_valid),
    .pop   (pop),
    .din   (llu_bus),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_NORMAL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_NORMAL:
        if (!fifo_empty && !pop && (starve_cnt == SW'(STARVE_MAX - 1)))
          state_next = ARB_FORCE;
      ARB_FORCE: state_next = ARB_NORMAL;
      default:   state_next = ARB_NORMAL;
    endcase
  end

  always_comb begin
    lanes_ready = (state == ARB_NORMAL);
    force_slot  = (state == ARB_FORCE);
  end

  // Slot allocation: lanes keep their own port, the LLU head fills the first free one.
  always_comb begin
    p1     = b1;
    p2     = b2;
    p1_vld = 1'b0;
    p2_vld = 1'b0;
    p1_llu = 1'b0;
    p2_llu = 1'b0;
    pop    = 1'b0;
    if (force_slot) begin
      p1     = head;
      p1_vld = !fifo_empty;
      p1_llu = 1'b1;
      pop    = !fifo_empty;
    end else begin
      p1_vld = l1_valid;
      p2_vld = l2_valid;
      if (!fifo_empty) begin
        if (!l1_valid) begin
          p1     = head;
          p1_vld = 1'b1;
          p1_llu = 1'b1;
          pop    = 1'b1;
        end else if (!l2_valid) begin
          p2     = head;
          p2_vld = 1'b1;
          p2_llu = 1'b1;
          pop    = 1'b1;
        end
      end
    end
  end

  // WAW: younger lane2 beats lane1; any lane write beats the older LLU result.
  always_comb begin
    l1_wr = lanes_ready && l1_valid && b1.we && (b1.dest != '0);
    l2_wr = lanes_ready && l2_valid && b2.we && (b2.dest != '0);
    p1_we = p1_vld && p1.we && (p1.dest != '0);
    p2_we = p2_vld && p2.we && (p2.dest != '0);
    if (p1_llu) begin
      if ((l1_wr && (p1.dest == b1.dest)) || (l2_wr && (p1.dest == b2.dest)))
        p1_we = 1'b0;
    end else if (l2_wr && (p1.dest == b2.dest)) begin
      p1_we = 1'b0;
    end
    if (p2_llu && ((l1_wr && (p2.dest == b1.dest)) || (l2_wr && (p2.dest == b2.dest))))
      p2_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)                     starve_cnt <= '0;
    else if (fifo_empty || pop)    starve_cnt <= '0;
    else                           starve_cnt <= starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp1_we        <= 1'b0;
      wp1_addr      <= '0;
      wp1_data      <= '0;
      wp2_we        <= 1'b0;
      wp2_addr      <= '0;
      wp2_data      <= '0;
      llu_force_cnt <= '0;
    end else begin
      wp1_we   <= p1_we;
      wp1_addr <= p1.dest;
      wp1_data <= p1.result;
      wp2_we   <= p2_we;
      wp2_addr <= p2.dest;
      wp2_data <= p2.result;
      if (force_slot && (llu_force_cnt != '1))
        llu_force_cnt <= llu_force_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Bench for wb_wport_arbiter: directed scenarios then random traffic, every cycle checked
// against a queue-based model of the port scheduling rules.
module tb_wb_wport_arbiter;

  localparam int unsigned BW         = 70;
  localparam int unsigned STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lanes_ready;
  logic          l1_valid = 1'b0;
  logic [BW-1:0] l1_bus = '0;
  logic          l2_valid = 1'b0;
  logic [BW-1:0] l2_bus = '0;
  logic          llu_valid = 1'b0;
  logic          llu_ready;
  logic [BW-1:0] llu_bus = '0;
  logic          wp1_we;
  logic [4:0]    wp1_addr;
  logic [31:0]   wp1_data;
  logic          wp2_we;
  logic [4:0]    wp2_addr;
  logic [31:0]   wp2_data;
  logic [31:0]   llu_force_cnt;

  wb_wport_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .lanes_ready   (lanes_ready),
    .l1_valid      (l1_valid),
    .l1_bus        (l1_bus),
    .l2_valid      (l2_valid),
    .l2_bus        (l2_bus),
    .llu_valid     (llu_valid),
    .llu_ready     (llu_ready),
    .llu_bus       (llu_bus),
    .wp1_we        (wp1_we),
    .wp1_addr      (wp1_addr),
    .wp1_data      (wp1_data),
    .wp2_we        (wp2_we),
    .wp2_addr      (wp2_addr),
    .wp2_data      (wp2_data),
    .llu_force_cnt (llu_force_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: pending LLU results, unserved-cycle count, pending forced slot.
  logic [BW-1:0] q[$];
  int            starve = 0;
  bit            forcing = 1'b0;
  logic [31:0]   fcnt = '0;
  bit            known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic we, input logic [4:0] d, input logic [31:0] r);
    return {we, d, r, 32'($urandom)};
  endfunction

  function automatic bit writes(input logic [BW-1:0] b);
    logic [4:0] d;
    d = b[68:64];
    return b[69] && (d != 5'd0);
  endfunction

  task automatic step(input bit rst, input bit v1, input logic [BW-1:0] bb1,
                      input bit v2, input logic [BW-1:0] bb2,
                      input bit vl, input logic [BW-1:0] bl);
    bit            s1v, s2v, s1l, s2l, popped, was_forcing, lw1, lw2, e1, e2;
    logic [BW-1:0] s1b, s2b;
    logic [4:0]    d1, d2, sd1, sd2;
    int            sz;
    @(negedge clk);
    reset = rst; l1_valid = v1; l1_bus = bb1; l2_valid = v2; l2_bus = bb2;
    llu_valid = vl; llu_bus = bl;
    #1;
    if (known) begin
      chk("lanes_ready", 32'(lanes_ready), 32'(!forcing));
      chk("llu_ready", 32'(llu_ready), 32'(q.size() < 2));
    end
    s1v = 0; s2v = 0; s1l = 0; s2l = 0; s1b = '0; s2b = '0; e1 = 0; e2 = 0;
    if (rst) begin
      q.delete(); starve = 0; forcing = 0; fcnt = '0;
    end else begin
      sz = q.size(); popped = 0; was_forcing = forcing; forcing = 0;
      lw1 = !was_forcing && v1 && writes(bb1);
      lw2 = !was_forcing && v2 && writes(bb2);
      d1 = bb1[68:64]; d2 = bb2[68:64];
      if (was_forcing) begin
        if (sz > 0) begin s1v = 1; s1l = 1; s1b = q.pop_front(); popped = 1; end
        if (fcnt != 32'hFFFF_FFFF) fcnt++;
      end else begin
        s1v = v1; s1b = bb1; s2v = v2; s2b = bb2;
        if (sz > 0 && !v1) begin s1v = 1; s1l = 1; s1b = q.pop_front(); popped = 1; end
        else if (sz > 0 && !v2) begin s2v = 1; s2l = 1; s2b = q.pop_front(); popped = 1; end
      end
      if (sz > 0 && !popped) begin
        if (!was_forcing && starve == STARVE_MAX - 1) forcing = 1;
        starve++;
      end else starve = 0;
      if (vl && sz < 2) q.push_back(bl);
      sd1 = s1b[68:64]; sd2 = s2b[68:64];
      e1 = s1v && writes(s1b);
      e2 = s2v && writes(s2b);
      if (s1l) e1 = e1 && !((lw1 && sd1 == d1) || (lw2 && sd1 == d2));
      else     e1 = e1 && !(lw1 && lw2 && d1 == d2);
      if (s2l) e2 = e2 && !((lw1 && sd2 == d1) || (lw2 && sd2 == d2));
    end
    @(posedge clk);
    #1;
    if (rst) known = 1'b1;
    chk("wp1_we", 32'(wp1_we), 32'(e1));
    chk("wp2_we", 32'(wp2_we), 32'(e2));
    if (s1v) begin
      chk("wp1_addr", 32'(wp1_addr), 32'(s1b[68:64]));
      chk("wp1_data", wp1_data, s1b[63:32]);
    end
    if (s2v) begin
      chk("wp2_addr", 32'(wp2_addr), 32'(s2b[68:64]));
      chk("wp2_data", wp2_data, s2b[63:32]);
    end
    chk("llu_force_cnt", llu_force_cnt, fcnt);
  endtask

  initial begin
    logic [BW-1:0] z;
    bit saw_force;
    z = '0;

    // Reset with every valid raised
    for (int i = 0; i < 3; i++)
      step(1, 1, mk(1, 5'd1, 32'h1), 1, mk(1, 5'd2, 32'h2), 1, mk(1, 5'd3, 32'h3));
    chk("rst_lanes_ready", 32'(lanes_ready), 32'd1);
    chk("rst_llu_ready", 32'(llu_ready), 32'd1);

    // Independent lane writes
    step(0, 1, mk(1, 5'd5, 32'hAAAA), 1, mk(1, 5'd6, 32'hBBBB), 0, z);
    chk("t2_wp1_data", wp1_data, 32'hAAAA);
    chk("t2_wp2_addr", 32'(wp2_addr), 32'd6);

    // Lane WAW and dest-0
    step(0, 1, mk(1, 5'd7, 32'h1), 1, mk(1, 5'd7, 32'h2), 0, z);
    chk("t3_waw_wp1_we", 32'(wp1_we), 32'd0);
    chk("t3_waw_wp2_data", wp2_data, 32'h2);
    step(0, 1, mk(1, 5'd0, 32'h1), 1, mk(1, 5'd0, 32'h2), 0, z);
    chk("t3_d0_we", 32'({wp1_we, wp2_we}), 32'd0);

    // LLU result takes the free port2 one cycle after the push
    step(0, 1, mk(1, 5'd1, 32'h10), 0, z, 1, mk(1, 5'd9, 32'h55));
    step(0, 1, mk(1, 5'd2, 32'h20), 0, z, 0, z);
    chk("t4_wp2_we", 32'(wp2_we), 32'd1);
    chk("t4_wp2_addr", 32'(wp2_addr), 32'd9);
    chk("t4_wp2_data", wp2_data, 32'h55);
    step(0, 0, z, 0, z, 0, z);
    chk("t4_drained", 32'(wp1_we | wp2_we), 32'd0);

    // Starvation under full lane traffic forces an LLU slot
    saw_force = 0;
    step(0, 1, mk(1, 5'd10, 32'h100), 1, mk(1, 5'd11, 32'h101), 1, mk(1, 5'd12, 32'h77));
    for (int i = 0; i < 6; i++) begin
      step(0, 1, mk(1, 5'd10, 32'(i)), 1, mk(1, 5'd11, 32'(i)), 0, z);
      if (!lanes_ready) saw_force = 1;
    end
    chk("t5_saw_force", 32'(saw_force), 32'd1);
    chk("t5_force_cnt", llu_force_cnt, 32'd1);
    chk("t5_back_normal", 32'(lanes_ready), 32'd1);

    // Fill, refuse third push, LLU-vs-lane WAW, reset mid-fill
    step(0, 1, mk(1, 5'd20, 32'h1), 1, mk(1, 5'd21, 32'h2), 1, mk(1, 5'd3, 32'h33));
    step(0, 1, mk(1, 5'd20, 32'h3), 1, mk(1, 5'd21, 32'h4), 1, mk(1, 5'd4, 32'h44));
    chk("t6_full", 32'(llu_ready), 32'd0);
    step(0, 1, mk(1, 5'd20, 32'h5), 1, mk(1, 5'd21, 32'h6), 1, mk(1, 5'd8, 32'h88));
    step(0, 1, mk(1, 5'd3, 32'hC3), 0, z, 0, z);
    chk("t6_llu_waw_we", 32'(wp2_we), 32'd0);
    chk("t6_llu_waw_addr", 32'(wp2_addr), 32'd3);
    chk("t6_lane_we", 32'(wp1_we), 32'd1);
    chk("t6_popped", 32'(llu_ready), 32'd1);
    step(0, 1, mk(1, 5'd20, 32'h7), 1, mk(1, 5'd21, 32'h8), 1, mk(1, 5'd5, 32'h55));
    step(1, 0, z, 0, z, 0, z);
    step(0, 0, z, 0, z, 0, z);
    chk("t6_rst_empty", 32'(llu_ready), 32'd1);
    chk("t6_rst_no_write", 32'(wp1_we | wp2_we), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom),
           $urandom_range(0, 3) != 0,
           mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom),
           $urandom_range(0, 2) == 0,
           mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
